// File: rtl/sram_responder.sv
// sram_responder: clocked stand-in for the 16-bit asynchronous SRAM chip on the controller's bus.
// Byte-masked writes, fixed-latency pipelined reads onto a tri-state DQ, and wrapping access counters.
module sram_responder #(
  parameter int ADDR_W       = 18,
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [15:0]       SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LAST  = READ_LATENCY - 1;

  logic [15:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  wr_en;
  logic                  rd_cap;
  logic                  drive_en;
  logic                  unused_addr_hi;

  logic [READ_LATENCY-1:0]       vld_q, vld_d;
  logic [READ_LATENCY-1:0]       ub_q, ub_d;
  logic [READ_LATENCY-1:0]       lb_q, lb_d;
  logic [READ_LATENCY-1:0][15:0] data_q, data_d;
  logic [CNT_W-1:0]              wr_count_q, wr_count_d;
  logic [CNT_W-1:0]              rd_count_q, rd_count_d;

  // Upper address bits are ignored, so addresses alias every DEPTH words.
  assign idx            = SRAM_ADDR[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^SRAM_ADDR[ADDR_W-1:DEPTH_LOG2];
  assign wr_en          = !SRAM_CE_N && !SRAM_WE_N;
  assign rd_cap         = !SRAM_CE_N && SRAM_WE_N;

  // The array is deliberately left out of reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      if (!SRAM_UB_N) mem[idx][15:8] <= SRAM_DQ[15:8];
      if (!SRAM_LB_N) mem[idx][7:0]  <= SRAM_DQ[7:0];
    end
  end

  always_comb begin
    vld_d      = vld_q;
    ub_d       = ub_q;
    lb_d       = lb_q;
    data_d     = data_q;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;

    vld_d[0] = rd_cap;
    if (rd_cap) begin
      data_d[0] = mem[idx];
      ub_d[0]   = SRAM_UB_N;
      lb_d[0]   = SRAM_LB_N;
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      ub_d[i]   = ub_q[i-1];
      lb_d[i]   = lb_q[i-1];
      data_d[i] = data_q[i-1];
    end

    if (wr_en)  wr_count_d = wr_count_q + CNT_W'(1);
    if (rd_cap) rd_count_d = rd_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      ub_q       <= '1;
      lb_q       <= '1;
      data_q     <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
    end else begin
      vld_q      <= vld_d;
      ub_q       <= ub_d;
      lb_q       <= lb_d;
      data_q     <= data_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
    end
  end

  // Drive gating uses the live pins, so WE_N falling releases the bus within the same cycle.
  assign drive_en = !rst && vld_q[LAST] && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;

  assign SRAM_DQ[15:8] = (drive_en && !ub_q[LAST]) ? data_q[LAST][15:8] : 8'hzz;
  assign SRAM_DQ[7:0]  = (drive_en && !lb_q[LAST]) ? data_q[LAST][7:0]  : 8'hzz;

  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;

endmodule
